// File: rtl/dna_ctrl_pkg.sv
// Shared constants, FSM state type and small helpers for the DNA read controller.
package dna_ctrl_pkg;

   localparam int          DNA_W           = 96;
   localparam int          TIMEOUT_CYC_DEF = 32;
   localparam logic [6:0]  SHIFT_BITS      = 7'd96;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      ARB        = 3'd1,
      START      = 3'd2,
      WAIT_VALID = 3'd3,
      SHIFT      = 3'd4,
      SETTLE     = 3'd5,
      RESP       = 3'd6
   } state_t;

   // Shift counter increment that sticks at all-ones so overlong streams never wrap to 96.
   function automatic logic [6:0] sat_inc7(input logic [6:0] v);
      logic [6:0] r;
      if (v == 7'h7F) begin
         r = v;
      end else begin
         r = v + 7'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/dna_read_ctrl_rr_arbiter.sv
// Round-robin arbiter: search starts at the pointer, pointer moves past the winner on advance.
module rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   input  logic             advance,
   output logic [N_REQ-1:0] grant,
   output logic [IDX_W-1:0] index
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] cand;
   logic             found;

   // First requester at or after the pointer, wrapping around.
   always_comb begin
      grant = {N_REQ{1'b0}};
      index = {IDX_W{1'b0}};
      cand  = {IDX_W{1'b0}};
      found = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         cand = IDX_W'((int'(ptr) + i) % N_REQ);
         if (!found && req[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
            index       = cand;
         end else begin
            found = found;
         end
      end
   end

   // Pointer register: next search begins just after the last winner.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= {IDX_W{1'b0}};
      end else if (advance) begin
         ptr <= (index == LAST_IDX) ? {IDX_W{1'b0}} : index + IDX_W'(1);
      end else begin
         ptr <= ptr;
      end
   end

endmodule

// File: rtl/dna_read_ctrl.sv
// Arbitrated front end for a device-DNA reader; one requester is served per read.
// Optional result caching is enabled by defining DNA_READ_CTRL_CACHE_EN.
module dna_read_ctrl
   import dna_ctrl_pkg::*;
#(
   parameter int N_REQ       = 4,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req_i,
   output logic [N_REQ-1:0] ack_o,
   output logic [DNA_W-1:0] dna_o,
   output logic             err_o,
   output logic             busy_o,
   output logic             dna_start_o,
   input  logic             dna_ser_valid_i,
   input  logic [DNA_W-1:0] dna_i
);

   localparam int               IDX_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int               WAIT_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);

   state_t            state;
   logic [IDX_W-1:0]  owner;
   logic [WAIT_W-1:0] wait_cnt;
   logic [6:0]        shift_cnt;
   logic [N_REQ-1:0]  arb_grant;
   logic [IDX_W-1:0]  arb_index;
   logic              arb_advance;
`ifdef DNA_READ_CTRL_CACHE_EN
   logic              cache_valid;
`endif

   function automatic logic [N_REQ-1:0] owner_onehot(input logic [IDX_W-1:0] idx);
      logic [N_REQ-1:0] v;
      v      = {N_REQ{1'b0}};
      v[idx] = 1'b1;
      return v;
   endfunction

   assign arb_advance = (state == ARB) && (|arb_grant);

   rr_arbiter #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req_i),
      .advance (arb_advance),
      .grant   (arb_grant),
      .index   (arb_index)
   );

   // Read sequencer; all outputs are registered, ack/err/start default low every cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         owner       <= {IDX_W{1'b0}};
         wait_cnt    <= {WAIT_W{1'b0}};
         shift_cnt   <= 7'd0;
         ack_o       <= {N_REQ{1'b0}};
         dna_o       <= {DNA_W{1'b0}};
         err_o       <= 1'b0;
         busy_o      <= 1'b0;
         dna_start_o <= 1'b0;
`ifdef DNA_READ_CTRL_CACHE_EN
         cache_valid <= 1'b0;
`endif
      end else begin
         ack_o       <= {N_REQ{1'b0}};
         err_o       <= 1'b0;
         dna_start_o <= 1'b0;
         case (state)
            IDLE: begin
               wait_cnt  <= {WAIT_W{1'b0}};
               shift_cnt <= 7'd0;
               if (|req_i) begin
                  state  <= ARB;
                  busy_o <= 1'b1;
               end else begin
                  state  <= IDLE;
                  busy_o <= 1'b0;
               end
            end
            ARB: begin
               if (|arb_grant) begin
                  owner <= arb_index;
`ifdef DNA_READ_CTRL_CACHE_EN
                  if (cache_valid) begin
                     // dna_o still holds the last good read, so it doubles as the cache.
                     state <= RESP;
                     ack_o <= arb_grant;
                  end else begin
                     state       <= START;
                     dna_start_o <= 1'b1;
                  end
`else
                  state       <= START;
                  dna_start_o <= 1'b1;
`endif
               end else begin
                  state  <= IDLE;
                  busy_o <= 1'b0;
               end
            end
            START: begin
               wait_cnt <= {WAIT_W{1'b0}};
               state    <= WAIT_VALID;
            end
            WAIT_VALID: begin
               if (dna_ser_valid_i) begin
                  // The first valid cycle is already the first shifted bit.
                  shift_cnt <= 7'd1;
                  state     <= SHIFT;
               end else if (wait_cnt == WAIT_LAST) begin
                  state <= RESP;
                  ack_o <= owner_onehot(owner);
                  err_o <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end
            SHIFT: begin
               if (dna_ser_valid_i) begin
                  shift_cnt <= sat_inc7(shift_cnt);
               end else if (shift_cnt == SHIFT_BITS) begin
                  state <= SETTLE;
               end else begin
                  state <= RESP;
                  ack_o <= owner_onehot(owner);
                  err_o <= 1'b1;
               end
            end
            SETTLE: begin
               dna_o <= dna_i;
`ifdef DNA_READ_CTRL_CACHE_EN
               cache_valid <= 1'b1;
`endif
               state <= RESP;
               ack_o <= owner_onehot(owner);
            end
            RESP: begin
               state  <= IDLE;
               busy_o <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               busy_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dna_read_ctrl.sv
// Randomized bench for dna_read_ctrl with a transaction-level reference model.
module tb_dna_read_ctrl;

   localparam int N   = 4;
   localparam int TMO = 32;
`ifdef DNA_READ_CTRL_CACHE_EN
   localparam bit CACHE_EN = 1'b1;
`else
   localparam bit CACHE_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic [N-1:0]  req_i;
   logic [N-1:0]  ack_o;
   logic [95:0]   dna_o;
   logic          err_o;
   logic          busy_o;
   logic          dna_start_o;
   logic          dna_ser_valid_i;
   logic [95:0]   dna_i;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   int          m_ptr;
   bit          m_cache;
   logic [95:0] m_dna;

   dna_read_ctrl #(.N_REQ(N), .TIMEOUT_CYC(TMO)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .req_i           (req_i),
      .ack_o           (ack_o),
      .dna_o           (dna_o),
      .err_o           (err_o),
      .busy_o          (busy_o),
      .dna_start_o     (dna_start_o),
      .dna_ser_valid_i (dna_ser_valid_i),
      .dna_i           (dna_i)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   function automatic int rr_pick(input logic [N-1:0] mask, input int from);
      for (int i = 0; i < N; i++) begin
         if (mask[(from + i) % N]) return (from + i) % N;
      end
      return 0;
   endfunction

   function automatic logic [95:0] rnd96();
      return {$urandom, $urandom, $urandom};
   endfunction

   task automatic model_reset();
      m_ptr   = 0;
      m_cache = 1'b0;
      m_dna   = 96'd0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ack"},   ack_o,       0);
      check({tag, "_dna"},   dna_o,       0);
      check({tag, "_err"},   err_o,       0);
      check({tag, "_busy"},  busy_o,      0);
      check({tag, "_start"}, dna_start_o, 0);
   endtask

   task automatic do_reset();
      rst_n           = 1'b0;
      req_i           = '0;
      dna_ser_valid_i = 1'b0;
      step();
      check("reset_busy", busy_o, 0);
      rst_n = 1'b1;
      step();
      model_reset();
   endtask

   // One request/response; abort_at>0 pulls reset after that many valid cycles.
   task automatic txn(input string name, input logic [N-1:0] mask, input int delay,
                      input int nvalid, input logic [95:0] truth, input bit hold,
                      input bit drop, input int abort_at);
      int owner, exp_err, exp_starts;
      logic [95:0] exp_dna, got_dna, prev_dna;
      logic [N-1:0] got_ack;
      logic got_err;
      bit hit, done, aborted;
      int req_cyc, start_cyc, vbeg, vend, vcnt, ack_cyc, starts, bad;
      got_dna = '0; got_ack = '0; got_err = 1'b0;
      done = 1'b0; aborted = 1'b0;
      start_cyc = -1; vbeg = -1; vend = -1; vcnt = 0; ack_cyc = -1; starts = 0; bad = 0;
      if (!hold) begin
         req_i = '0;
         step();
      end
      owner = rr_pick(mask, m_ptr);
      m_ptr = (owner + 1) % N;
      hit = CACHE_EN && m_cache;
      exp_starts = hit ? 0 : 1;
      if (hit) begin
         exp_err = 0; exp_dna = m_dna;
      end else if (delay >= TMO || nvalid != 96) begin
         exp_err = 1; exp_dna = m_dna;
      end else begin
         exp_err = 0; exp_dna = truth; m_dna = truth; m_cache = 1'b1;
      end
      req_i    = mask;
      req_cyc  = cyc;
      prev_dna = dna_o;
      for (int k = 0; k < 400 && !done; k++) begin
         step();
         if (dna_start_o) begin
            starts++;
            start_cyc = cyc;
            vbeg = cyc + 1 + delay;
            vend = vbeg + nvalid;
            if (drop) req_i = '0;
            if (!busy_o) bad++;
         end
         if ($countones(ack_o) > 1) bad++;
         if (ack_o != '0) begin
            got_ack = ack_o; got_dna = dna_o; got_err = err_o;
            ack_cyc = cyc; done = 1'b1;
            if (!busy_o) bad++;
         end else begin
            if (err_o) bad++;
            if (dna_o !== prev_dna) bad++;
         end
         dna_ser_valid_i = (vbeg >= 0 && cyc >= vbeg && cyc < vend);
         if (dna_ser_valid_i) vcnt++;
         dna_i = (vend >= 0 && cyc >= vend) ? truth : rnd96();
         if (abort_at > 0 && vcnt == abort_at && !done) begin
            #3;
            rst_n = 1'b0;
            #1;
            check_all_zero({name, "_async"});
            req_i = '0;
            dna_ser_valid_i = 1'b0;
            step();
            check({name, "_noack0"}, ack_o, 0);
            step();
            check({name, "_noack1"}, ack_o, 0);
            rst_n = 1'b1;
            step();
            model_reset();
            aborted = 1'b1;
            done = 1'b1;
         end
      end
      dna_ser_valid_i = 1'b0;
      if (!aborted) begin
         check({name, "_done"},   done,    1);
         check({name, "_ack"},    got_ack, 96'(1) << owner);
         check({name, "_err"},    got_err, exp_err);
         check({name, "_dna"},    got_dna, exp_dna);
         check({name, "_starts"}, starts,  exp_starts);
         check({name, "_proto"},  bad,     0);
         if (hit) begin
            if (!hold) check({name, "_lat"}, ack_cyc - req_cyc, 2);
         end else if (delay >= TMO) begin
            check({name, "_lat"}, ack_cyc - start_cyc, TMO + 1);
         end else begin
            check({name, "_lat"}, ack_cyc - vend, (nvalid == 96) ? 2 : 1);
         end
      end
   endtask

   initial begin
      int nv;
      rst_n = 1'b0;
      req_i = '0;
      dna_ser_valid_i = 1'b0;
      dna_i = '0;
      model_reset();
      step();
      step();
      check_all_zero("reset");
      rst_n = 1'b1;
      step();

      txn("single", 4'b0001, 3, 96, 96'h0123_4567_89AB_CDEF_0011_2233, 1'b0, 1'b0, 0);
      txn("rstshift", 4'b0100, 2, 96, rnd96(), 1'b0, 1'b0, 40);

      txn("cont0", 4'b1011, $urandom_range(0, 10), 96, rnd96(), 1'b0, 1'b0, 0);
      for (int i = 1; i < 4; i++) begin
         txn("contn", 4'b1011, $urandom_range(0, 10), 96, rnd96(), 1'b1, 1'b0, 0);
      end

      do_reset();
      txn("timeout", 4'b0001, 40, 96, rnd96(), 1'b0, 1'b0, 0);
      txn("short", 4'b0010, 5, 95, rnd96(), 1'b0, 1'b0, 0);
      txn("good", 4'b0100, 7, 96, rnd96(), 1'b0, 1'b0, 0);
      txn("cache", 4'b0010, 4, 96, rnd96(), 1'b0, 1'b0, 0);

      do_reset();
      for (int i = 0; i < 12; i++) begin
         case ($urandom_range(0, 5))
            0:       nv = 95;
            1:       nv = 97;
            2:       nv = $urandom_range(1, 120);
            default: nv = 96;
         endcase
         txn("rand", 4'($urandom_range(1, 15)), $urandom_range(0, 36), nv, rnd96(),
             1'b0, ($urandom_range(0, 3) == 0), 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
